// File: rtl/sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_anim_ctrl
//  Description : Per-fighter animation sequencer (IDLE / WALK / ATTACK) that
//                advances once per video frame, plus a scaled, optionally
//                mirrored sprite-ROM address generator driven by the VGA scan
//                position. Sprites are stored as a frame strip in one ROM:
//                frame 0 = idle, 1..WALK_FRAMES = walk cycle, followed by
//                ATK_FRAMES attack frames.
//
//  Ports       : vga_clk      - pixel clock (only clock)
//                reset_n      - synchronous active-low reset
//                vsync        - VGA vsync, active high; rising edge = tick
//                DrawX/DrawY  - current scan position
//                player_x/_y  - hitbox top-left corner
//                walk_req     - level, fighter moving
//                attack_req   - pulse or level, attack button
//                facing_left  - mirror sprite horizontally (latched on tick)
//                rom_address  - registered sprite ROM address
//                pixel_valid  - registered, scan position inside hitbox
//                frame_idx    - global frame number currently displayed
//                busy         - attack animation in progress
//
//  Build macro : ATTACK_QUEUE_EN - when defined, one attack request seen
//                during an attack is queued and replayed when it finishes.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_ctrl #(
    parameter int SPRITE_W    = 60,
    parameter int SPRITE_H    = 90,
    parameter int BOX_W       = 80,
    parameter int BOX_H       = 160,
    parameter int WALK_FRAMES = 6,
    parameter int ATK_FRAMES  = 4,
    parameter int HOLD_TICKS  = 6,
    parameter int ADDR_W      = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic              walk_req,
    input  logic              attack_req,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_address,
    output logic              pixel_valid,
    output logic [3:0]        frame_idx,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WALK   = 2'd1;
    localparam logic [1:0] ST_ATTACK = 2'd2;

    localparam int HOLD_BW   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

    localparam logic [HOLD_BW-1:0] HOLD_LAST = HOLD_BW'(HOLD_TICKS - 1);
    localparam logic [3:0]         WALK_LAST = 4'(WALK_FRAMES - 1);
    localparam logic [3:0]         ATK_LAST  = 4'(ATK_FRAMES - 1);
    localparam logic [3:0]         ATK_BASE  = 4'(1 + WALK_FRAMES);

`ifdef ATTACK_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Animation state
    // ------------------------------------------------------------------
    logic [1:0]         state, state_n;
    logic [3:0]         wi, wi_n;
    logic [3:0]         ai, ai_n;
    logic [HOLD_BW-1:0] hold, hold_n;
    logic               attack_pend, pend_n;
    logic               vsync_q;
    logic               facing_q;

    logic               tick;
    logic               pend_or;
    logic               hold_wrap;
    logic [HOLD_BW-1:0] hold_inc;

    assign tick      = vsync & ~vsync_q;
    // A request in the tick cycle itself must be visible to that tick.
    assign pend_or   = attack_pend | attack_req;
    assign hold_wrap = (hold == HOLD_LAST);
    assign hold_inc  = hold_wrap ? '0 : hold + 1'b1;

    always_comb begin
        state_n = state;
        wi_n    = wi;
        ai_n    = ai;
        hold_n  = hold;
        pend_n  = pend_or;

        if (tick) begin
            pend_n = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend_or) begin
                        state_n = ST_ATTACK;
                        ai_n    = '0;
                        hold_n  = '0;
                    end else if (walk_req) begin
                        state_n = ST_WALK;
                        wi_n    = '0;
                        hold_n  = '0;
                    end
                end
                ST_WALK: begin
                    if (pend_or) begin
                        state_n = ST_ATTACK;
                        ai_n    = '0;
                        hold_n  = '0;
                    end else if (!walk_req) begin
                        state_n = ST_IDLE;
                        wi_n    = '0;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_inc;
                        if (hold_wrap) begin
                            wi_n = (wi == WALK_LAST) ? 4'd0 : wi + 4'd1;
                        end
                    end
                end
                ST_ATTACK: begin
                    // Attacks are uninterruptible; a request is either
                    // kept for replay or dropped.
                    pend_n = QUEUE_EN ? pend_or : 1'b0;
                    hold_n = hold_inc;
                    if (hold_wrap) begin
                        if (ai == ATK_LAST) begin
                            ai_n = '0;
                            if (QUEUE_EN && pend_or) begin
                                state_n = ST_ATTACK;
                                pend_n  = 1'b0;
                            end else if (walk_req) begin
                                state_n = ST_WALK;
                                wi_n    = '0;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            ai_n = ai + 4'd1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    wi_n    = '0;
                    ai_n    = '0;
                    hold_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wi          <= '0;
            ai          <= '0;
            hold        <= '0;
            attack_pend <= 1'b0;
            facing_q    <= 1'b0;
            // Pretend vsync was already high so a high vsync at release
            // does not look like a rising edge.
            vsync_q     <= 1'b1;
        end else begin
            state       <= state_n;
            wi          <= wi_n;
            ai          <= ai_n;
            hold        <= hold_n;
            attack_pend <= pend_n;
            vsync_q     <= vsync;
            if (tick) begin
                facing_q <= facing_left;
            end
        end
    end

    always_comb begin
        frame_idx = 4'd0;
        case (state)
            ST_WALK:   frame_idx = 4'd1 + wi;
            ST_ATTACK: frame_idx = ATK_BASE + ai;
            default:   frame_idx = 4'd0;
        endcase
    end

    assign busy = (state == ST_ATTACK);

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic signed [10:0] rx, ry;
    logic [31:0]        rx_u, ry_u;
    logic [31:0]        sx, sy, sx_m;
    logic [31:0]        base;
    logic               in_box;
    logic [ADDR_W-1:0]  addr_next;

    assign rx = $signed({1'b0, DrawX}) - $signed({1'b0, player_x});
    assign ry = $signed({1'b0, DrawY}) - $signed({1'b0, player_y});

    // Only meaningful when the sign bit is clear; in_box masks the rest.
    assign rx_u = {21'd0, rx};
    assign ry_u = {21'd0, ry};

    assign in_box = ~rx[10] && (rx_u < 32'(BOX_W)) &&
                    ~ry[10] && (ry_u < 32'(BOX_H));

    // Box-to-sprite scaling with truncation (constant divisors).
    assign sx   = (rx_u * 32'(SPRITE_W)) / 32'(BOX_W);
    assign sy   = (ry_u * 32'(SPRITE_H)) / 32'(BOX_H);
    assign sx_m = facing_q ? (32'(SPRITE_W) - 32'd1 - sx) : sx;
    assign base = 32'(frame_idx) * 32'(FRAME_PIX);

    assign addr_next = ADDR_W'(base + sy * 32'(SPRITE_W) + sx_m);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address <= '0;
            pixel_valid <= 1'b0;
        end else begin
            rom_address <= in_box ? addr_next : '0;
            pixel_valid <= in_box;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_anim_ctrl
//  Description : Self-checking bench for sprite_anim_ctrl. Pixel addresses go
//                through a scoreboard queue; animation frames are compared
//                against closed-form expectations after each vsync tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [9:0]  player_x = '0, player_y = '0;
    logic        walk_req = 1'b0;
    logic        attack_req = 1'b0;
    logic        facing_left = 1'b0;
    logic [15:0] rom_address;
    logic        pixel_valid;
    logic [3:0]  frame_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sprite_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .player_x    (player_x),
        .player_y    (player_y),
        .walk_req    (walk_req),
        .attack_req  (attack_req),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .pixel_valid (pixel_valid),
        .frame_idx   (frame_idx),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        ev;
        logic [15:0] ea;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] a;
        string       nm;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one scan position, queue its expectation, compare one clock later.
    task automatic pix(input logic [9:0] dx, input logic [9:0] dy,
                       input logic ev, input logic [15:0] ea, input string nm);
        exp_t e;
        @(negedge vga_clk);
        DrawX = dx;
        DrawY = dy;
        e.v = ev;
        e.a = ea;
        e.nm = nm;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check({e.nm, "_valid"}, 32'(pixel_valid), 32'(e.v));
            check({e.nm, "_addr"}, 32'(rom_address), 32'(e.a));
        end
    endtask

    // One vsync rising edge; optionally assert attack_req in the tick cycle.
    task automatic tick(input bit with_atk);
        @(negedge vga_clk);
        vsync = 1'b1;
        attack_req = with_atk;
        @(negedge vga_clk);
        vsync = 1'b0;
        attack_req = 1'b0;
        repeat (2) @(negedge vga_clk);
    endtask

    task automatic atk_pulse();
        @(negedge vga_clk);
        attack_req = 1'b1;
        @(negedge vga_clk);
        attack_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle frame 0, player at (100,100), no mirroring.
        vecs[0] = '{10'd100, 10'd100, 1'b1, 16'd0};
        vecs[1] = '{10'd179, 10'd259, 1'b1, 16'd5399};
        vecs[2] = '{10'd180, 10'd259, 1'b0, 16'd0};
        vecs[3] = '{10'd99,  10'd100, 1'b0, 16'd0};
        vecs[4] = '{10'd100, 10'd99,  1'b0, 16'd0};
        vecs[5] = '{10'd179, 10'd100, 1'b1, 16'd59};
        vecs[6] = '{10'd100, 10'd259, 1'b1, 16'd5340};
        vecs[7] = '{10'd140, 10'd180, 1'b1, 16'd2730};
        vecs[8] = '{10'd0,   10'd0,   1'b0, 16'd0};
        vecs[9] = '{10'd100, 10'd260, 1'b0, 16'd0};

        // Reset state
        repeat (3) @(negedge vga_clk);
        check("rst_addr",  32'(rom_address), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_frame", 32'(frame_idx),   32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        player_x = 10'd100;
        player_y = 10'd100;
        reset_n = 1'b1;
        repeat (2) @(negedge vga_clk);

        for (int i = 0; i < 10; i++) begin
            pix(vecs[i].dx, vecs[i].dy, vecs[i].ev, vecs[i].ea, $sformatf("idle_vec%0d", i));
        end

        // Walk cycle: each frame held 6 ticks, 6 frames then wrap.
        walk_req = 1'b1;
        for (int n = 1; n <= 37; n++) begin
            tick(1'b0);
            check($sformatf("walk_frame_t%0d", n), 32'(frame_idx), 32'(1 + ((n - 1) / 6) % 6));
            check("walk_busy", 32'(busy), 32'd0);
            if (n == 13) pix(10'd100, 10'd100, 1'b1, 16'd16200, "walk_addr_f3");
        end

        // Mirroring takes effect only on the next tick.
        facing_left = 1'b1;
        pix(10'd100, 10'd100, 1'b1, 16'd5400, "face_before_tick");
        tick(1'b0);
        check("face_frame", 32'(frame_idx), 32'd1);
        pix(10'd100, 10'd100, 1'b1, 16'd5459, "face_tl");
        pix(10'd179, 10'd100, 1'b1, 16'd5400, "face_tr");

        // Attack while walking, second request during the attack.
        atk_pulse();
        tick(1'b0);
        check("atk_enter_frame", 32'(frame_idx), 32'd7);
        check("atk_enter_busy",  32'(busy),      32'd1);
        for (int k = 1; k <= 24; k++) begin
            if (k == 4) atk_pulse();
            tick(1'b0);
            if (k < 24) begin
                check($sformatf("atk_frame_k%0d", k), 32'(frame_idx), 32'(7 + k / 6));
                check("atk_busy", 32'(busy), 32'd1);
            end else begin
`ifdef ATTACK_QUEUE_EN
                check("atk_exit_frame", 32'(frame_idx), 32'd7);
                check("atk_exit_busy",  32'(busy),      32'd1);
`else
                check("atk_exit_frame", 32'(frame_idx), 32'd1);
                check("atk_exit_busy",  32'(busy),      32'd0);
`endif
            end
        end

        // Get into an attack, then reset for one cycle with vsync high.
`ifndef ATTACK_QUEUE_EN
        atk_pulse();
        tick(1'b0);
`endif
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge vga_clk);
        vsync = 1'b1;
        reset_n = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        check("midrst_busy",  32'(busy),        32'd0);
        check("midrst_frame", 32'(frame_idx),   32'd0);
        check("midrst_addr",  32'(rom_address), 32'd0);
        check("midrst_valid", 32'(pixel_valid), 32'd0);
        repeat (3) @(negedge vga_clk);
        check("release_no_tick", 32'(frame_idx), 32'd0);
        vsync = 1'b0;
        repeat (2) @(negedge vga_clk);
        check("release_no_tick2", 32'(frame_idx), 32'd0);
        tick(1'b0);
        check("post_rst_walk", 32'(frame_idx), 32'd1);

        // Attack request in the tick cycle itself, ending in IDLE.
        @(negedge vga_clk);
        reset_n = 1'b0;
        walk_req = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        tick(1'b1);
        check("same_cycle_atk_frame", 32'(frame_idx), 32'd7);
        check("same_cycle_atk_busy",  32'(busy),      32'd1);
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0);
            if (k < 24) begin
                check($sformatf("atk2_frame_k%0d", k), 32'(frame_idx), 32'(7 + k / 6));
            end else begin
                check("atk2_exit_frame", 32'(frame_idx), 32'd0);
                check("atk2_exit_busy",  32'(busy),      32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
